ans_window_acc: RTL

- Downstream consumer of the 4-bit arithmetic stage that produces ans1/ans2/ans3.
- Accumulates each of the three signed 4-bit result channels over a window of WINDOW accepted samples.
- At window end, emits per-channel saturating signed sums, a one-cycle out_valid pulse and per-channel overflow flags.
- A flush input ends a partial window early, so the block can feed a display/compare stage.

---
 rtl/ans_window_acc.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ans_window_acc.sv
// Windowed accumulator for the three signed 4-bit ans channels.
// Each window reports per-channel saturating sums and sticky overflow flags with a one-cycle out_valid pulse.
module ans_window_acc #(
    parameter int unsigned WINDOW = 4,
    parameter int unsigned ACC_W  = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       ans1,
    input  logic [3:0]       ans2,
    input  logic [3:0]       ans3,
    input  logic             flush,
    output logic             out_valid,
    output logic [ACC_W-1:0] sum1,
    output logic [ACC_W-1:0] sum2,
    output logic [ACC_W-1:0] sum3,
    output logic [2:0]       ovf,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    localparam int unsigned N_CH = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ACC_W-1:0] acc_q [N_CH];
    logic [ACC_W-1:0] acc_d [N_CH];
    logic [ACC_W-1:0] acc_nxt [N_CH];
    logic [ACC_W-1:0] sum_q [N_CH];
    logic [ACC_W-1:0] sum_d [N_CH];
    logic [2:0]       sticky_q, sticky_d, sticky_nxt;
    logic [2:0]       ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [3:0]       ans_in [N_CH];
    logic             window_full, flush_close;

    // Signed add of a 4-bit sample into the accumulator; returns {saturated, clamped result}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [3:0] x);
        logic [ACC_W:0]   wide;
        logic [ACC_W-1:0] res;
        logic             sat;
        wide = {acc[ACC_W-1], acc} + {{(ACC_W-3){x[3]}}, x};
        sat  = wide[ACC_W] != wide[ACC_W-1];
        res  = wide[ACC_W-1:0];
        if (sat) begin
            res = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return {sat, res};
    endfunction

    always_comb begin
        ans_in[0] = ans1;
        ans_in[1] = ans2;
        ans_in[2] = ans3;
    end

    // Per-channel candidate accumulator and sticky flags including this cycle's sample.
    always_comb begin
        sticky_nxt = sticky_q;
        for (int i = 0; i < N_CH; i++) begin
            logic [ACC_W:0] add_r;
            add_r      = sat_add(acc_q[i], ans_in[i]);
            acc_nxt[i] = acc_q[i];
            if (in_valid) begin
                acc_nxt[i]    = add_r[ACC_W-1:0];
                sticky_nxt[i] = sticky_q[i] | add_r[ACC_W];
            end
        end
    end

    // Window control: completion on the WINDOW-th accept or on flush of a non-empty window.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        sum_d       = sum_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;

        cnt_inc     = cnt_q + CNT_W'(in_valid);
        window_full = in_valid && (cnt_inc == CNT_W'(WINDOW));
        flush_close = flush && ((state_q == ACCUM) || in_valid);

        if (window_full || flush_close) begin
            sum_d       = acc_nxt;
            ovf_d       = sticky_nxt;
            out_valid_d = 1'b1;
            acc_d       = '{default: '0};
            sticky_d    = '0;
            cnt_d       = '0;
            state_d     = IDLE;
        end else begin
            acc_d    = acc_nxt;
            sticky_d = sticky_nxt;
            cnt_d    = cnt_inc;
            if (in_valid) begin
                state_d = ACCUM;
            end
        end

        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '{default: '0};
            sticky_q    <= '0;
            sum_q       <= '{default: '0};
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            sum_q       <= sum_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum1      = sum_q[0];
    assign sum2      = sum_q[1];
    assign sum3      = sum_q[2];
    assign ovf       = ovf_q;
    assign cnt       = cnt_q;
    assign busy      = busy_q;

endmodule
